// File: rtl/jt08_adpcm_ram_arb.sv
// rtl/jt08_adpcm_ram_arb.sv - ADPCM sample RAM arbiter: two requesters, fixed wait states, hold input, bounded priority
module jt08_adpcm_ram_arb #(
    parameter int AW      = 21,
    parameter int WAITS   = 4,
    parameter int MAXSKIP = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          mem_hold,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [7:0]    wdat0,
    input  logic [7:0]    wdat1,
    output logic          ack0,
    output logic          ack1,
    output logic [7:0]    rdata,
    output logic [1:0]    grant,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dout,
    input  logic [7:0]    mem_din,
    output logic          mem_oe_n,
    output logic          mem_we_n
);
    localparam int WW = $clog2(WAITS + 1);
    localparam int SW = (MAXSKIP > 0) ? $clog2(MAXSKIP + 1) : 1;

    typedef enum logic [1:0] {IDLE, STROBE, RELEASE} state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wcnt, wcnt_nx;
    logic [SW-1:0] skip, skip_nx;
    logic [1:0]    grant_nx;
    logic [AW-1:0] addr_nx;
    logic [7:0]    dout_nx, rdata_nx;
    logic          oe_nx, we_nx, ack0_nx, ack1_nx;
    logic          pick1;

    assign busy = (state != IDLE);

    // Port 1 wins when alone, or when port 0 has already won MAXSKIP times in a row against it
    assign pick1 = req1 && (!req0 || (MAXSKIP != 0 && skip == SW'(MAXSKIP)));

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        skip_nx  = skip;
        grant_nx = grant;
        addr_nx  = mem_addr;
        dout_nx  = mem_dout;
        rdata_nx = rdata;
        oe_nx    = mem_oe_n;
        we_nx    = mem_we_n;
        ack0_nx  = 1'b0;
        ack1_nx  = 1'b0;
        if (cen) begin
            case (state)
                IDLE: begin
                    if (!mem_hold && (req0 || req1)) begin
                        state_nx = STROBE;
                        wcnt_nx  = WW'(WAITS);
                        if (pick1) begin
                            grant_nx = 2'b10;
                            addr_nx  = addr1;
                            dout_nx  = wdat1;
                            we_nx    = !we1;
                            oe_nx    = we1;
                            skip_nx  = '0;
                        end else begin
                            grant_nx = 2'b01;
                            addr_nx  = addr0;
                            dout_nx  = wdat0;
                            we_nx    = !we0;
                            oe_nx    = we0;
                            if (req1 && skip != SW'(MAXSKIP))
                                skip_nx = skip + 1'b1;
                        end
                    end
                end
                STROBE: begin
                    if (!mem_hold) begin
                        if (wcnt == WW'(1)) begin
                            state_nx = RELEASE;
                            oe_nx    = 1'b1;
                            we_nx    = 1'b1;
                            if (!mem_oe_n)
                                rdata_nx = mem_din;
                        end else begin
                            wcnt_nx = wcnt - 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    state_nx = IDLE;
                    ack0_nx  = grant[0];
                    ack1_nx  = grant[1];
                    grant_nx = 2'b00;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wcnt     <= '0;
            skip     <= '0;
            grant    <= 2'b00;
            mem_addr <= '0;
            mem_dout <= 8'h00;
            rdata    <= 8'h00;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
        end else begin
            state    <= state_nx;
            wcnt     <= wcnt_nx;
            skip     <= skip_nx;
            grant    <= grant_nx;
            mem_addr <= addr_nx;
            mem_dout <= dout_nx;
            rdata    <= rdata_nx;
            mem_oe_n <= oe_nx;
            mem_we_n <= we_nx;
            ack0     <= ack0_nx;
            ack1     <= ack1_nx;
        end
    end
endmodule

// File: tb/tb_jt08_adpcm_ram_arb.sv
// tb/tb_jt08_adpcm_ram_arb.sv - directed bench for the ADPCM RAM arbiter
module tb_jt08_adpcm_ram_arb;
    localparam int AW = 21;

    logic          clk = 1'b0;
    logic          rst, cen, mem_hold;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [7:0]    wdat0, wdat1, mem_din;
    logic          ack0, ack1, busy, mem_oe_n, mem_we_n;
    logic [7:0]    rdata, mem_dout;
    logic [1:0]    grant;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int passed = 0;
    int n;
    logic saw_oe;
    int exp_g [8] = '{1, 1, 1, 2, 1, 1, 1, 2};

    jt08_adpcm_ram_arb #(.AW(AW), .WAITS(4), .MAXSKIP(3)) dut (
        .clk(clk), .rst(rst), .cen(cen), .mem_hold(mem_hold),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdat0(wdat0), .wdat1(wdat1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .grant(grant), .busy(busy),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cen_edge();
        cen = 1'b1;
        @(posedge clk);
        #1;
        cen = 1'b0;
    endtask

    task automatic idle_clk(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts cen edges until both strobes are released, bounded
    task automatic count_strobe(output int cnt);
        cnt = 0;
        while (!(mem_oe_n && mem_we_n) && cnt < 40) begin
            cen_edge();
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; mem_hold = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdat0 = 8'h00; wdat1 = 8'h00; mem_din = 8'h00;
        idle_clk(2);
        chk("reset_oe_n", mem_oe_n, 1);
        chk("reset_we_n", mem_we_n, 1);
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_acks", {ack0, ack1}, 0);
        rst = 1'b0;
        idle_clk(1);

        // Single read on port 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 21'h1F0; mem_din = 8'hA5;
        cen_edge();
        chk("rd_grant", grant, 2'b01);
        chk("rd_oe_low", mem_oe_n, 0);
        chk("rd_addr", mem_addr, 21'h1F0);
        chk("rd_busy", busy, 1);
        count_strobe(n);
        chk("rd_strobe_cens", n, 4);
        chk("rd_rdata", rdata, 8'hA5);
        chk("rd_no_early_ack", ack0, 0);
        cen_edge();
        chk("rd_ack0", ack0, 1);
        chk("rd_grant_clear", grant, 0);
        req0 = 1'b0; mem_din = 8'h5A;
        idle_clk(1);
        chk("rd_ack_width", ack0, 0);
        chk("rd_rdata_stable", rdata, 8'hA5);

        // Write on port 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 21'h00010; wdat1 = 8'h3C;
        cen_edge();
        chk("wr_grant", grant, 2'b10);
        chk("wr_we_low", mem_we_n, 0);
        chk("wr_addr", mem_addr, 21'h10);
        chk("wr_dout", mem_dout, 8'h3C);
        saw_oe = 1'b0;
        n = 0;
        while (!mem_we_n && n < 40) begin
            if (!mem_oe_n) saw_oe = 1'b1;
            cen_edge();
            n++;
        end
        chk("wr_strobe_cens", n, 4);
        chk("wr_oe_stays_high", saw_oe, 0);
        cen_edge();
        chk("wr_ack1", ack1, 1);
        chk("wr_rdata_unchanged", rdata, 8'hA5);
        req1 = 1'b0;
        idle_clk(1);

        // Contention with MAXSKIP=3
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        for (int t = 0; t < 8; t++) begin
            cen_edge();
            chk($sformatf("cont_grant_%0d", t), grant, exp_g[t]);
            repeat (4) cen_edge();
            cen_edge();
            chk($sformatf("cont_ack_%0d", t), {ack1, ack0}, exp_g[t]);
        end
        req0 = 1'b0; req1 = 1'b0;
        cen_edge();
        chk("cont_idle", busy, 0);

        // Hold for 6 cen in the middle of a strobe
        req0 = 1'b1; mem_din = 8'h77;
        cen_edge();
        chk("hold_grant", grant, 2'b01);
        n = 0;
        while (!mem_oe_n && n < 40) begin
            if (n == 2) mem_hold = 1'b1;
            if (n == 8) mem_hold = 1'b0;
            cen_edge();
            n++;
        end
        chk("hold_strobe_cens", n, 10);
        cen_edge();
        chk("hold_ack0", ack0, 1);
        chk("hold_rdata", rdata, 8'h77);
        req0 = 1'b0;

        // Hold in IDLE blocks new grants
        mem_hold = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 21'h00300;
        repeat (3) cen_edge();
        chk("hold_idle_grant", grant, 0);
        chk("hold_idle_busy", busy, 0);
        mem_hold = 1'b0;
        cen_edge();
        chk("hold_release_grant", grant, 2'b10);

        // Asynchronous reset in mid strobe
        repeat (2) cen_edge();
        rst = 1'b1;
        #1;
        chk("rst_oe_n", mem_oe_n, 1);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", mem_addr, 0);
        cen = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_no_ack_%0d", k), {ack0, ack1}, 0);
        end
        cen = 1'b0;
        rst = 1'b0;
        we1 = 1'b1; addr1 = 21'h00022; wdat1 = 8'h99;
        cen_edge();
        chk("post_rst_grant", grant, 2'b10);
        chk("post_rst_addr", mem_addr, 21'h22);
        count_strobe(n);
        chk("post_rst_strobe", n, 4);
        cen_edge();
        chk("post_rst_ack1", ack1, 1);
        req1 = 1'b0;

        // cen asserted one clk in eight
        idle_clk(3);
        req0 = 1'b1; we0 = 1'b0; addr0 = 21'h1ABCD; mem_din = 8'hC3;
        cen_edge();
        chk("cen8_grant", grant, 2'b01);
        idle_clk(7);
        chk("cen8_grant_hold", grant, 2'b01);
        n = 0;
        saw_oe = 1'b0;
        while (!mem_oe_n && n < 40) begin
            cen_edge();
            n++;
            if (n < 4 && mem_oe_n) saw_oe = 1'b1;
            idle_clk(7);
            if (n < 4 && mem_oe_n) saw_oe = 1'b1;
        end
        chk("cen8_strobe_cens", n, 4);
        chk("cen8_no_early_release", saw_oe, 0);
        chk("cen8_no_ack_yet", ack0, 0);
        cen_edge();
        chk("cen8_ack0", ack0, 1);
        req0 = 1'b0;
        idle_clk(1);
        chk("cen8_ack_width", ack0, 0);
        chk("cen8_rdata", rdata, 8'hC3);
        chk("cen8_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
